// File: rtl/ws2812_pkg.sv
// Shared types and constants for the LED frame streamer.
package ws2812_pkg;
  localparam int GRB_W            = 24;
  localparam int LATCH_CYCLES_DEF = 2600;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    LATCH  = 2'd2
  } state_t;
endpackage

// File: rtl/gap_counter.sv
// Latch-gap timer: a start pulse arms it, done is high during the last of
// LATCH_CYCLES counted cycles, then it disarms itself.
module gap_counter
  import ws2812_pkg::*;
#(
  parameter int LATCH_CYCLES = LATCH_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic done
);
  localparam int CW = $clog2(LATCH_CYCLES + 1);

  logic [CW-1:0] r_cnt;
  logic          r_active;

  assign done = r_active && (r_cnt == CW'(LATCH_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (start) begin
      r_cnt    <= '0;
      r_active <= 1'b1;
    end else if (r_active) begin
      if (done) r_active <= 1'b0;
      else      r_cnt    <= r_cnt + CW'(1);
    end
  end
endmodule

// File: rtl/led_frame_streamer.sv
// Streams NUM_LEDS GRB words from pixel memory to a serializer, then holds a
// latch gap. Define ROTATE_EN to advance the start offset every frame (chase).
module led_frame_streamer
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS     = 8,
  parameter int LATCH_CYCLES = LATCH_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             stop,
  input  logic             wr_en,
  input  logic [7:0]       wr_addr,
  input  logic [GRB_W-1:0] wr_data,
  output logic [GRB_W-1:0] pix_data,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             busy,
  output logic             frame_done,
  output logic [7:0]       led_index
);
  localparam int AW    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0]   N_EXT = (AW+1)'(NUM_LEDS);
  localparam logic [AW-1:0] LAST  = AW'(NUM_LEDS - 1);

  // (a + b) mod NUM_LEDS for operands already below NUM_LEDS
  function automatic logic [AW-1:0] mod_add(input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [AW:0] s;
    logic [AW:0] w;
    s = {1'b0, a} + {1'b0, b};
    w = s - N_EXT;
    return (s >= N_EXT) ? w[AW-1:0] : s[AW-1:0];
  endfunction

  state_t           r_state;
  logic [AW-1:0]    r_idx;
  logic [GRB_W-1:0] r_mem [DEPTH];

  logic [AW-1:0] w_offset;
  logic [AW-1:0] w_rd_addr;
  logic          w_xfer;
  logic          w_end_stream;
  logic          w_gap_done;
  logic          w_wr_ok;

  assign w_xfer       = (r_state == STREAM) && pix_ready;
  assign w_end_stream = (r_state == STREAM) && (stop || (w_xfer && (r_idx == LAST)));
  assign w_wr_ok      = wr_en && ({1'b0, wr_addr} < 9'(NUM_LEDS));
  assign w_rd_addr    = mod_add(w_offset, r_idx);

  assign pix_valid  = (r_state == STREAM);
  assign busy       = (r_state != IDLE);
  assign frame_done = (r_state == LATCH) && w_gap_done;
  assign pix_data   = pix_valid ? r_mem[w_rd_addr] : '0;
  assign led_index  = 8'(r_idx);

  gap_counter #(.LATCH_CYCLES(LATCH_CYCLES)) u_gap (
    .clk   (clk),
    .reset (reset),
    .start (w_end_stream),
    .done  (w_gap_done)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
    end else if (w_wr_ok) begin
      r_mem[wr_addr[AW-1:0]] <= wr_data;
    end
  end

`ifdef ROTATE_EN
  logic [AW-1:0] r_offset;
  always_ff @(posedge clk) begin
    if (!reset)          r_offset <= '0;
    else if (frame_done) r_offset <= mod_add(r_offset, AW'(1));
  end
  assign w_offset = r_offset;
`else
  assign w_offset = '0;
`endif

  // r_idx is only nonzero in STREAM, so led_index reads 0 elsewhere
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (go && !stop) begin
            r_state <= STREAM;
            r_idx   <= '0;
          end
        end
        STREAM: begin
          if (w_end_stream) begin
            r_state <= LATCH;
            r_idx   <= '0;
          end else if (w_xfer) begin
            r_idx <= r_idx + AW'(1);
          end
        end
        LATCH: begin
          if (w_gap_done) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_led_frame_streamer.sv
// Randomized self-checking bench for led_frame_streamer (NUM_LEDS=4).
module tb_led_frame_streamer;
  localparam int N  = 4;
  localparam int LC = 2600;

  logic        clk = 1'b0;
  logic        reset, go, stop, wr_en, pix_ready;
  logic [7:0]  wr_addr;
  logic [23:0] wr_data;
  logic [23:0] pix_data;
  logic        pix_valid, busy, frame_done;
  logic [7:0]  led_index;

  always #5 clk = ~clk;

  led_frame_streamer #(.NUM_LEDS(N), .LATCH_CYCLES(LC)) dut (
    .clk(clk), .reset(reset), .go(go), .stop(stop),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .busy(busy), .frame_done(frame_done), .led_index(led_index)
  );

  int vectors = 0;
  int errors  = 0;

  // reference model: pixel array and frame start offset
  logic [23:0] m_mem [N];
  int          m_off;

  logic [23:0] q_dat [$];
  int          q_idx [$];
  int          q_cyc [$];
  int          stall_bad, gap_len, n_done, valid_after_gap;
  logic        post_busy;
  bit          timed_out;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input int a, input logic [23:0] d);
    wr_en = 1'b1; wr_addr = 8'(a); wr_data = d;
    tick();
    wr_en = 1'b0;
    if (a < N) m_mem[a] = d;
  endtask

  task automatic do_reset();
    reset = 1'b0; go = 0; stop = 0; wr_en = 0; wr_addr = 0; wr_data = 0; pix_ready = 0;
    tick(); tick();
    reset = 1'b1;
    for (int i = 0; i < N; i++) m_mem[i] = '0;
    m_off = 0;
  endtask

  task automatic advance_off();
`ifdef ROTATE_EN
    m_off = (m_off + 1) % N;
`endif
  endtask

  // mode 0: ready always, 1: ready one cycle in three, 2: random ready
  task automatic run_frame(input int mode, input int stop_at, input bit noise_go);
    logic pv, pr;
    logic [23:0] pd;
    logic [7:0]  pi;
    bit rdy;
    q_dat.delete(); q_idx.delete(); q_cyc.delete();
    stall_bad = 0; gap_len = 0; n_done = 0; valid_after_gap = 0; post_busy = 1'b1;
    timed_out = 1; pv = 0; pr = 0; pd = '0; pi = '0;
    go = 1; stop = 0;
    for (int cyc = 0; cyc < LC + 200; cyc++) begin
      tick();
      go = 0; stop = 0;
      if (pv && !pr && pix_valid && (pix_data !== pd || led_index !== pi)) stall_bad++;
      if (busy && !pix_valid) gap_len++;
      if (pix_valid && gap_len > 0) valid_after_gap++;
      if (frame_done) begin
        n_done++;
        tick();
        post_busy = busy;
        timed_out = 0;
        break;
      end
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 2) : 1'($urandom_range(0, 1));
      pix_ready = rdy;
      if (pix_valid && rdy) begin
        q_dat.push_back(pix_data); q_idx.push_back(int'(led_index)); q_cyc.push_back(cyc);
        if (stop_at > 0 && q_dat.size() == stop_at) stop = 1;
      end
      if (noise_go && busy) go = 1'($urandom_range(0, 1));
      pv = pix_valid; pr = rdy; pd = pix_data; pi = led_index;
    end
    pix_ready = 0; go = 0; stop = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0; go = 0; stop = 0; wr_en = 0; wr_addr = 0; wr_data = 0; pix_ready = 0;
    tick();
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", pix_valid); end
    vectors++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", frame_done); end
    vectors++; if (pix_data !== 24'h0) begin errors++; $display("FAIL reset_data got %h want 0", pix_data); end
    vectors++; if (led_index !== 8'h0) begin errors++; $display("FAIL reset_index got %0d want 0", led_index); end
    do_reset();
  endtask

  task automatic test_basic();
    wr(0, 24'h0000FF); wr(1, 24'h00FF00); wr(2, 24'hFF0000); wr(3, 24'hFFFFFF);
    run_frame(0, 0, 0);
    vectors++; if (q_dat.size() !== N) begin errors++; $display("FAIL basic_count got %0d want %0d", q_dat.size(), N); end
    for (int i = 0; i < q_dat.size() && i < N; i++) begin
      vectors++; if (q_dat[i] !== m_mem[(m_off+i)%N]) begin errors++; $display("FAIL basic_data[%0d] got %h want %h", i, q_dat[i], m_mem[(m_off+i)%N]); end
      vectors++; if (q_idx[i] !== i) begin errors++; $display("FAIL basic_index[%0d] got %0d want %0d", i, q_idx[i], i); end
      vectors++; if (q_cyc[i] !== q_cyc[0] + i) begin errors++; $display("FAIL basic_consec[%0d] got %0d want %0d", i, q_cyc[i], q_cyc[0]+i); end
    end
    vectors++; if (timed_out !== 1'b0) begin errors++; $display("FAIL basic_timeout got 1 want 0"); end
    vectors++; if (gap_len !== LC) begin errors++; $display("FAIL basic_gap got %0d want %0d", gap_len, LC); end
    vectors++; if (n_done !== 1) begin errors++; $display("FAIL basic_done got %0d want 1", n_done); end
    vectors++; if (post_busy !== 1'b0) begin errors++; $display("FAIL basic_idle got %b want 0", post_busy); end
    if (n_done == 1) advance_off();
  endtask

  task automatic test_stall();
    for (int i = 0; i < N; i++) wr(i, 24'($urandom));
    run_frame(1, 0, 0);
    vectors++; if (q_dat.size() !== N) begin errors++; $display("FAIL stall_count got %0d want %0d", q_dat.size(), N); end
    for (int i = 0; i < q_dat.size() && i < N; i++) begin
      vectors++; if (q_dat[i] !== m_mem[(m_off+i)%N]) begin errors++; $display("FAIL stall_data[%0d] got %h want %h", i, q_dat[i], m_mem[(m_off+i)%N]); end
    end
    vectors++; if (stall_bad !== 0) begin errors++; $display("FAIL stall_stable got %0d changes want 0", stall_bad); end
    vectors++; if (n_done !== 1) begin errors++; $display("FAIL stall_done got %0d want 1", n_done); end
    if (n_done == 1) advance_off();
  endtask

  task automatic test_random_go_noise();
    for (int i = 0; i < N; i++) wr(i, 24'($urandom));
    run_frame(2, 0, 1);
    vectors++; if (q_dat.size() !== N) begin errors++; $display("FAIL noise_count got %0d want %0d", q_dat.size(), N); end
    for (int i = 0; i < q_dat.size() && i < N; i++) begin
      vectors++; if (q_dat[i] !== m_mem[(m_off+i)%N]) begin errors++; $display("FAIL noise_data[%0d] got %h want %h", i, q_dat[i], m_mem[(m_off+i)%N]); end
    end
    vectors++; if (stall_bad !== 0) begin errors++; $display("FAIL noise_stable got %0d changes want 0", stall_bad); end
    vectors++; if (gap_len !== LC) begin errors++; $display("FAIL noise_gap got %0d want %0d", gap_len, LC); end
    vectors++; if (post_busy !== 1'b0) begin errors++; $display("FAIL noise_idle got %b want 0", post_busy); end
    if (n_done == 1) advance_off();
  endtask

  task automatic test_stop();
    run_frame(0, 2, 0);
    vectors++; if (q_dat.size() !== 2) begin errors++; $display("FAIL stop_count got %0d want 2", q_dat.size()); end
    for (int i = 0; i < q_dat.size() && i < 2; i++) begin
      vectors++; if (q_dat[i] !== m_mem[(m_off+i)%N]) begin errors++; $display("FAIL stop_data[%0d] got %h want %h", i, q_dat[i], m_mem[(m_off+i)%N]); end
    end
    vectors++; if (valid_after_gap !== 0) begin errors++; $display("FAIL stop_novalid got %0d want 0", valid_after_gap); end
    vectors++; if (gap_len !== LC) begin errors++; $display("FAIL stop_gap got %0d want %0d", gap_len, LC); end
    vectors++; if (n_done !== 1) begin errors++; $display("FAIL stop_done got %0d want 1", n_done); end
    if (n_done == 1) advance_off();
  endtask

  task automatic test_go_stop_idle();
    go = 1; stop = 1;
    tick();
    go = 0; stop = 0;
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL gostop_busy got %b want 0", busy); end
    vectors++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL gostop_valid got %b want 0", pix_valid); end
    tick();
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL gostop_busy2 got %b want 0", busy); end
  endtask

  task automatic test_write();
    logic [23:0] nv;
    bit fin;
    wr(N, 24'($urandom)); wr(255, 24'($urandom)); wr($urandom_range(N, 254), 24'($urandom));
    go = 1; pix_ready = 0;
    tick();
    go = 0;
    vectors++; if (pix_data !== m_mem[m_off]) begin errors++; $display("FAIL wr_before got %h want %h", pix_data, m_mem[m_off]); end
    nv = 24'($urandom);
    wr(m_off, nv);
    vectors++; if (pix_data !== nv) begin errors++; $display("FAIL wr_live got %h want %h", pix_data, nv); end
    vectors++; if (led_index !== 8'd0) begin errors++; $display("FAIL wr_index got %0d want 0", led_index); end
    pix_ready = 1; fin = 0;
    for (int c = 0; c < LC + 50; c++) begin
      tick();
      if (!busy) begin fin = 1; break; end
    end
    pix_ready = 0;
    vectors++; if (fin !== 1'b1) begin errors++; $display("FAIL wr_finish got busy want idle"); end
    if (fin) advance_off();
    run_frame(0, 0, 0);
    vectors++; if (q_dat.size() !== N) begin errors++; $display("FAIL wr_count got %0d want %0d", q_dat.size(), N); end
    for (int i = 0; i < q_dat.size() && i < N; i++) begin
      vectors++; if (q_dat[i] !== m_mem[(m_off+i)%N]) begin errors++; $display("FAIL wr_data[%0d] got %h want %h", i, q_dat[i], m_mem[(m_off+i)%N]); end
    end
    if (n_done == 1) advance_off();
  endtask

  task automatic test_reset_mid();
    int dn;
    go = 1;
    tick();
    go = 0; pix_ready = 1;
    tick(); tick();
    reset = 0;
    tick();
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
    vectors++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b want 0", pix_valid); end
    vectors++; if (pix_data !== 24'h0) begin errors++; $display("FAIL rmid_data got %h want 0", pix_data); end
    vectors++; if (led_index !== 8'h0) begin errors++; $display("FAIL rmid_index got %0d want 0", led_index); end
    reset = 1; pix_ready = 0;
    for (int i = 0; i < N; i++) m_mem[i] = '0;
    m_off = 0;
    dn = 0;
    for (int c = 0; c < LC + 50; c++) begin
      tick();
      if (frame_done) dn++;
    end
    vectors++; if (dn !== 0) begin errors++; $display("FAIL rmid_nodone got %0d want 0", dn); end
    run_frame(0, 0, 0);
    vectors++; if (q_dat.size() !== N) begin errors++; $display("FAIL rmid_count got %0d want %0d", q_dat.size(), N); end
    for (int i = 0; i < q_dat.size() && i < N; i++) begin
      vectors++; if (q_dat[i] !== m_mem[(m_off+i)%N]) begin errors++; $display("FAIL rmid_cleared[%0d] got %h want %h", i, q_dat[i], m_mem[(m_off+i)%N]); end
    end
    if (n_done == 1) advance_off();
  endtask

  task automatic test_rotate();
    do_reset();
    for (int i = 0; i < N; i++) wr(i, {8'(i + 1), 16'($urandom)});
    run_frame(0, 0, 0);
    vectors++; if (q_dat.size() !== N) begin errors++; $display("FAIL rot1_count got %0d want %0d", q_dat.size(), N); end
    else begin
      vectors++; if (q_dat[0] !== m_mem[0]) begin errors++; $display("FAIL rot1_first got %h want %h", q_dat[0], m_mem[0]); end
    end
    if (n_done == 1) advance_off();
    run_frame(0, 0, 0);
    vectors++; if (q_dat.size() !== N) begin errors++; $display("FAIL rot2_count got %0d want %0d", q_dat.size(), N); end
    else begin
`ifdef ROTATE_EN
      vectors++; if (q_dat[0] !== m_mem[1]) begin errors++; $display("FAIL rot2_first got %h want %h", q_dat[0], m_mem[1]); end
      vectors++; if (q_dat[N-1] !== m_mem[0]) begin errors++; $display("FAIL rot2_last got %h want %h", q_dat[N-1], m_mem[0]); end
`else
      vectors++; if (q_dat[0] !== m_mem[0]) begin errors++; $display("FAIL rot2_first got %h want %h", q_dat[0], m_mem[0]); end
      vectors++; if (q_dat[N-1] !== m_mem[N-1]) begin errors++; $display("FAIL rot2_last got %h want %h", q_dat[N-1], m_mem[N-1]); end
`endif
    end
    if (n_done == 1) advance_off();
  endtask

  initial begin
    m_off = 0;
    for (int i = 0; i < N; i++) m_mem[i] = '0;
    test_reset();
    test_basic();
    test_stall();
    test_random_go_noise();
    test_stop();
    test_go_stop_idle();
    test_write();
    test_reset_mid();
    test_rotate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
